// File: rtl/trace_retire_fifo.sv
// Retirement trace buffer: captures retired-instruction records into a circular FIFO,
// tags them with a sequence number and opcode class, and drops on overflow without stalling the core.
module trace_retire_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ret_valid_i,
    input  logic [31:0]   ret_pc_i,
    input  logic [31:0]   ret_insn_i,
    input  logic [4:0]    ret_rd_addr_i,
    input  logic [31:0]   ret_rd_wdata_i,
    input  logic [31:0]   ret_mem_addr_i,
    input  logic          ret_trap_i,
    output logic          rec_valid_o,
    input  logic          rec_ready_i,
    output logic [31:0]   rec_pc_o,
    output logic [31:0]   rec_insn_o,
    output logic [31:0]   rec_rd_wdata_o,
    output logic [31:0]   rec_mem_addr_o,
    output logic [4:0]    rec_rd_addr_o,
    output logic          rec_trap_o,
    output logic [2:0]    rec_class_o,
    output logic [31:0]   rec_seq_o,
    output logic [AW:0]   level_o,
    output logic [15:0]   drop_cnt_o,
    output logic          overflow_o
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic        trap;
        logic [2:0]  cls;
        logic [31:0] seq;
    } rec_t;

    rec_t mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   seq_q, seq_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;

    logic          full, empty, push, pop, drop_ev;
    logic [2:0]    ret_class;
    rec_t          wr_rec;
    rec_t          head;

    always_comb begin
        ret_class = 3'd0;
        if (ret_insn_i[1:0] != 2'b11) begin
            ret_class = 3'd7;
        end else begin
            case (ret_insn_i[6:0])
                7'h03, 7'h07:                      ret_class = 3'd1;
                7'h23, 7'h27:                      ret_class = 3'd2;
                7'h63:                             ret_class = 3'd3;
                7'h6f, 7'h67:                      ret_class = 3'd4;
                7'h73:                             ret_class = 3'd5;
                7'h43, 7'h47, 7'h4b, 7'h4f, 7'h53: ret_class = 3'd6;
                default:                           ret_class = 3'd0;
            endcase
        end
    end

    always_comb begin
        wr_rec          = '0;
        wr_rec.pc       = ret_pc_i;
        wr_rec.insn     = ret_insn_i;
        wr_rec.rd_addr  = ret_rd_addr_i;
        wr_rec.rd_wdata = (ret_rd_addr_i == 5'd0) ? '0 : ret_rd_wdata_i;
        wr_rec.mem_addr = (ret_class == 3'd1 || ret_class == 3'd2) ? ret_mem_addr_i : '0;
        wr_rec.trap     = ret_trap_i;
        wr_rec.cls      = ret_class;
        wr_rec.seq      = seq_q;
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        pop     = !rst_i && !empty && rec_ready_i;
        push    = !rst_i && ret_valid_i && (!full || pop);
        drop_ev = !rst_i && ret_valid_i && full && !pop;

        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) count_d = count_q + (AW+1)'(1);
        if (pop && !push) count_d = count_q - (AW+1)'(1);
        seq_d      = (!rst_i && ret_valid_i) ? seq_q + 32'd1 : seq_q;
        drop_cnt_d = (drop_ev && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        overflow_d = overflow_q | drop_ev;

        if (rst_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            seq_d      = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        rec_valid_o    = !empty;
        rec_pc_o       = head.pc;
        rec_insn_o     = head.insn;
        rec_rd_addr_o  = head.rd_addr;
        rec_rd_wdata_o = head.rd_wdata;
        rec_mem_addr_o = head.mem_addr;
        rec_trap_o     = head.trap;
        rec_class_o    = head.cls;
        rec_seq_o      = head.seq;
        level_o        = count_q;
        drop_cnt_o     = drop_cnt_q;
        overflow_o     = overflow_q;
    end

endmodule

// File: tb/tb_trace_retire_fifo.sv
// Self-checking bench for trace_retire_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model of the retirement buffer.
module tb_trace_retire_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ret_valid;
    logic [31:0]   ret_pc, ret_insn, ret_rd_wdata, ret_mem_addr;
    logic [4:0]    ret_rd_addr;
    logic          ret_trap;
    logic          rec_ready;
    logic          rec_valid;
    logic [31:0]   rec_pc, rec_insn, rec_rd_wdata, rec_mem_addr, rec_seq;
    logic [4:0]    rec_rd_addr;
    logic          rec_trap;
    logic [2:0]    rec_class;
    logic [AW:0]   level;
    logic [15:0]   drop_cnt;
    logic          overflow;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    typedef struct {
        logic [31:0] pc, insn, rd_wdata, mem_addr, seq;
        logic [4:0]  rd_addr;
        logic        trap;
        logic [2:0]  cls;
    } mrec_t;

    mrec_t       mq[$];
    logic [31:0] m_seq;
    int unsigned m_drop;
    logic        m_ovf;

    trace_retire_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_insn_i(ret_insn),
        .ret_rd_addr_i(ret_rd_addr), .ret_rd_wdata_i(ret_rd_wdata),
        .ret_mem_addr_i(ret_mem_addr), .ret_trap_i(ret_trap),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
        .rec_pc_o(rec_pc), .rec_insn_o(rec_insn), .rec_rd_wdata_o(rec_rd_wdata),
        .rec_mem_addr_o(rec_mem_addr), .rec_rd_addr_o(rec_rd_addr),
        .rec_trap_o(rec_trap), .rec_class_o(rec_class), .rec_seq_o(rec_seq),
        .level_o(level), .drop_cnt_o(drop_cnt), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] class_of(input logic [31:0] insn);
        if (insn[1:0] != 2'b11) return 3'd7;
        case (insn[6:0])
            7'h03, 7'h07: return 3'd1;
            7'h23, 7'h27: return 3'd2;
            7'h63:        return 3'd3;
            7'h6f, 7'h67: return 3'd4;
            7'h73:        return 3'd5;
            7'h43, 7'h47, 7'h4b, 7'h4f, 7'h53: return 3'd6;
            default:      return 3'd0;
        endcase
    endfunction

    // Reference behaviour for one rising edge, using the inputs presented before it.
    task automatic model_edge();
        mrec_t r;
        bit    popped;
        if (rst) begin
            mq.delete();
            m_seq  = '0;
            m_drop = 0;
            m_ovf  = 1'b0;
            return;
        end
        popped = (mq.size() != 0) && rec_ready;
        if (popped) void'(mq.pop_front());
        if (ret_valid) begin
            if (mq.size() < DEPTH) begin
                r.pc       = ret_pc;
                r.insn     = ret_insn;
                r.rd_addr  = ret_rd_addr;
                r.rd_wdata = (ret_rd_addr == 0) ? 32'd0 : ret_rd_wdata;
                r.cls      = class_of(ret_insn);
                r.mem_addr = (r.cls == 3'd1 || r.cls == 3'd2) ? ret_mem_addr : 32'd0;
                r.trap     = ret_trap;
                r.seq      = m_seq;
                mq.push_back(r);
            end else begin
                if (m_drop < 16'hFFFF) m_drop++;
                m_ovf = 1'b1;
            end
            m_seq = m_seq + 32'd1;
        end
    endtask

    task automatic compare_all();
        check_eq("level", 64'(level), 64'(mq.size()));
        check_eq("rec_valid", 64'(rec_valid), 64'(mq.size() != 0));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            check_eq("pc", 64'(rec_pc), 64'(mq[0].pc));
            check_eq("insn", 64'(rec_insn), 64'(mq[0].insn));
            check_eq("rd_addr", 64'(rec_rd_addr), 64'(mq[0].rd_addr));
            check_eq("rd_wdata", 64'(rec_rd_wdata), 64'(mq[0].rd_wdata));
            check_eq("mem_addr", 64'(rec_mem_addr), 64'(mq[0].mem_addr));
            check_eq("trap", 64'(rec_trap), 64'(mq[0].trap));
            check_eq("class", 64'(rec_class), 64'(mq[0].cls));
            check_eq("seq", 64'(rec_seq), 64'(mq[0].seq));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rand_fields();
        logic [6:0] ops [17];
        logic [31:0] w;
        ops = '{7'h03, 7'h07, 7'h23, 7'h27, 7'h63, 7'h6f, 7'h67, 7'h73, 7'h43,
                7'h47, 7'h4b, 7'h4f, 7'h53, 7'h13, 7'h33, 7'h37, 7'h17};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 16)];
        if ($urandom_range(0, 9) == 0) w[1:0] = 2'($urandom_range(0, 2));
        ret_insn     = w;
        ret_pc       = $urandom;
        ret_rd_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        ret_rd_wdata = $urandom;
        ret_mem_addr = $urandom | 32'h1;
        ret_trap     = ($urandom_range(0, 7) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; ret_valid = 1'b0; rec_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic retire(input int unsigned n);
        for (int i = 0; i < n; i++) begin
            rand_fields();
            ret_valid = 1'b1;
            cycle();
        end
        ret_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] cls_insn [6];
        logic [2:0]  cls_exp  [6];
        logic [31:0] hold_pc, hold_seq, hold_insn;

        rst = 1'b1; ret_valid = 1'b0; rec_ready = 1'b0;
        ret_pc = '0; ret_insn = '0; ret_rd_addr = '0; ret_rd_wdata = '0;
        ret_mem_addr = '0; ret_trap = 1'b0;
        m_seq = '0; m_drop = 0; m_ovf = 1'b0;
        do_reset();
        check_eq("reset_level", 64'(level), 64'd0);
        check_eq("reset_valid", 64'(rec_valid), 64'd0);

        // Single retire
        ret_valid = 1'b1; ret_pc = 32'h80; ret_insn = 32'h00000013;
        ret_rd_addr = 5'd0; ret_rd_wdata = 32'h1234_5678; ret_mem_addr = 32'h40; ret_trap = 1'b0;
        cycle();
        ret_valid = 1'b0;
        check_eq("single_valid", 64'(rec_valid), 64'd1);
        check_eq("single_class", 64'(rec_class), 64'd0);
        check_eq("single_seq", 64'(rec_seq), 64'd0);
        check_eq("single_wdata", 64'(rec_rd_wdata), 64'd0);
        check_eq("single_level", 64'(level), 64'd1);
        rec_ready = 1'b1;
        cycle();
        rec_ready = 1'b0;
        check_eq("single_drain_level", 64'(level), 64'd0);
        check_eq("single_drain_valid", 64'(rec_valid), 64'd0);

        // Class decode
        cls_insn = '{32'h0002a303, 32'h0062a023, 32'h00000063, 32'h0000006f, 32'h00000073, 32'h00000001};
        cls_exp  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        for (int i = 0; i < 6; i++) begin
            ret_valid = 1'b1; ret_insn = cls_insn[i]; ret_pc = 32'h100 + 32'(i * 4);
            ret_rd_addr = 5'd6; ret_rd_wdata = 32'hA0 + 32'(i); ret_mem_addr = 32'h1000 + 32'(i);
            cycle();
        end
        ret_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq("decode_class", 64'(rec_class), 64'(cls_exp[i]));
            check_eq("decode_maddr_nz", 64'(rec_mem_addr != 0), 64'(i < 2));
            rec_ready = 1'b1;
            cycle();
        end
        rec_ready = 1'b0;

        // Overflow
        do_reset();
        retire(11);
        check_eq("ovf_level", 64'(level), 64'd8);
        check_eq("ovf_drop", 64'(drop_cnt), 64'd3);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("ovf_drain_seq", 64'(rec_seq), 64'(i));
            rec_ready = 1'b1;
            cycle();
        end
        rec_ready = 1'b0;
        retire(1);
        check_eq("ovf_after_seq", 64'(rec_seq), 64'd11);

        // Full plus simultaneous pop
        do_reset();
        retire(8);
        rand_fields();
        ret_pc = 32'hDEAD0000; ret_valid = 1'b1; rec_ready = 1'b1;
        cycle();
        ret_valid = 1'b0;
        check_eq("fullpop_level", 64'(level), 64'd8);
        check_eq("fullpop_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                check_eq("fullpop_tail_pc", 64'(rec_pc), 64'hDEAD0000);
                check_eq("fullpop_tail_seq", 64'(rec_seq), 64'd8);
            end
            cycle();
        end
        rec_ready = 1'b0;

        // Backpressure stability, then streaming
        do_reset();
        retire(1);
        hold_pc = rec_pc; hold_seq = rec_seq; hold_insn = rec_insn;
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            ret_valid = 1'($urandom_range(0, 1));
            cycle();
            check_eq("stall_pc", 64'(rec_pc), 64'(hold_pc));
            check_eq("stall_seq", 64'(rec_seq), 64'(hold_seq));
            check_eq("stall_insn", 64'(rec_insn), 64'(hold_insn));
        end
        ret_valid = 1'b0;
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_fields();
            ret_valid = 1'b1;
            cycle();
            check_eq("stream_seq", 64'(rec_seq), 64'(i));
        end
        ret_valid = 1'b0;
        cycle();
        rec_ready = 1'b0;
        check_eq("stream_drop", 64'(drop_cnt), 64'd0);

        // Mid-operation reset
        do_reset();
        retire(10);
        rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rec_ready = 1'b0;
        check_eq("mid_level", 64'(level), 64'd5);
        check_eq("mid_drop", 64'(drop_cnt), 64'd2);
        rand_fields();
        rst = 1'b1; ret_valid = 1'b1; rec_ready = 1'b1;
        cycle();
        rst = 1'b0; ret_valid = 1'b0; rec_ready = 1'b0;
        check_eq("mid_rst_level", 64'(level), 64'd0);
        check_eq("mid_rst_valid", 64'(rec_valid), 64'd0);
        check_eq("mid_rst_drop", 64'(drop_cnt), 64'd0);
        check_eq("mid_rst_ovf", 64'(overflow), 64'd0);
        retire(1);
        check_eq("mid_rst_seq", 64'(rec_seq), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            ret_valid = ($urandom_range(0, 99) < 60);
            rec_ready = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 80));
            rst       = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0; ret_valid = 1'b0; rec_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
